pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forward controller for the 5-stage RISC-V core.
- Drives the stall and flush inputs of the PC register, IF/ID, ID/EX and EX/MEM pipeline registers.
- Generates the EX-stage operand forwarding selects.
- Sequences post-redirect fetch flushing through a small FSM and keeps a saturating stall-cycle performance counter.

Parameters:
- REDIRECT_CYCLES, 1, extra cycles IF/ID is flushed after a taken redirect, to cover fetch latency; legal range 0..15.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the next clk rising edge).
- id_rs1, id_rs2  in  5  source register indices of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2.
- ex_rs1, ex_rs2  in  5  source register indices held in ID/EX.
- ex_rd  in  5  destination register in EX.
- ex_reg_write  in  1  EX instruction writes the register file.
- ex_result_src  in  2  EX result select; 2'b01 = load.
- ex_redirect  in  1  taken branch, jal or jalr resolved in EX.
- mem_rd, wb_rd  in  5  destination registers in MEM and WB.
- mem_reg_write, wb_reg_write  in  1  MEM/WB instruction writes the register file.
- dmem_req  in  1  MEM stage has a data-memory access outstanding.
- dmem_ready  in  1  data memory completes the access this cycle.
- stall_pc, stall_ifid, stall_idex, stall_exmem  out  1  hold the corresponding register.
- flush_ifid, flush_idex  out  1  clear the corresponding register to a bubble.
- fwd_a_sel, fwd_b_sel  out  2  EX operand select: 00 = register file, 01 = WB, 10 = MEM.
- in_redirect  out  1  FSM is in state REDIRECT.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_pc=1.

Behaviour:
- Stall, flush and forward outputs are combinational from the inputs and registered state; they act in the same cycle.
- Only the FSM state, the redirect counter and stall_cycles are registered.
- While rst=0 (reset held):
  - flush_ifid = flush_idex = 1.
  - All stall outputs 0; fwd selects 00.
- At the reset edge: state ← RUN, redirect counter ← 0, stall_cycles ← 0.
- mem_wait = dmem_req & ~dmem_ready. Priority order, highest first:
  1. mem_wait:
     - All four stalls = 1; both flushes = 0.
     - FSM state and redirect counter held.
     - ex_redirect is ignored; it stays frozen in ID/EX and is taken once the wait ends.
  2. ex_redirect:
     - flush_ifid = flush_idex = 1; all stalls 0.
     - If REDIRECT_CYCLES > 0: state ← REDIRECT, counter ← REDIRECT_CYCLES.
     - Otherwise state stays RUN.
  3. Load-use hazard = ex_result_src==01 & ex_reg_write & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)):
     - stall_pc = stall_ifid = 1, flush_idex = 1 (one bubble).
     - Exactly one cycle, because the bubble clears the match.
  4. Otherwise: all stalls and flushes 0.
- FSM REDIRECT (only when not mem_wait):
  - flush_ifid = 1 each cycle; counter decrements.
  - When the counter reaches 1 and decrements, the next state is RUN.
  - A new ex_redirect here reloads the counter and also asserts flush_idex.
  - Load-use detection is suppressed in REDIRECT, since ID holds a killed instruction.
- Forwarding for fwd_a_sel (fwd_b_sel is identical using ex_rs2):
  - 10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1.
  - Else 01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1.
  - Else 00. MEM wins over WB.
- x0 (index 0) never triggers forwarding or a load-use stall.
- stall_cycles increments on every cycle with stall_pc=1 and saturates at all-ones with no wrap.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state enum {RUN, REDIRECT}.
  - Forward-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10.
  - RESULT_SRC_LOAD=2'b01.
- One sub-module, fwd_unit: purely combinational MEM/WB forwarding compare, instantiated once per operand.

Test Plan:
- Reset → all flushes 1, stalls 0, fwd 00. Release rst=1 → in_redirect=0, stall_cycles=0.
- Load-use: ex_result_src=01, ex_reg_write=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → one cycle of stall_pc=stall_ifid=flush_idex=1. Repeat with ex_rd=0 → no stall.
- Redirect with REDIRECT_CYCLES=2: ex_redirect pulse → cycle 0 flush_ifid=flush_idex=1; cycles 1-2 flush_ifid=1 and in_redirect=1; cycle 3 all 0.
- mem_wait during REDIRECT (dmem_req=1, dmem_ready=0 for 3 cycles):
  - All stalls 1, flushes 0, counter frozen, stall_cycles += 3.
  - Flushing then resumes for the remaining count.
- Forwarding: mem_rd=wb_rd=7, both reg_write=1, ex_rs1=7 → fwd_a_sel=10. Drop mem_reg_write → 01. ex_rs2=0 with wb_rd=0 → fwd_b_sel=00.
- Simultaneous ex_redirect and a load-use match → only redirect flushes, stall_pc=0. stall_cycles preloaded near all-ones then stalled → saturates, no wrap.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush/forward controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned RCNT_W = 4;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF          = 2'b00;
  localparam logic [1:0] FWD_WB          = 2'b01;
  localparam logic [1:0] FWD_MEM         = 2'b10;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding select for one source register; MEM beats WB, x0 never forwards.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic [1:0]       sel_c
);

  always_comb begin
    sel_c = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
      sel_c = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/forward controller for the 5-stage core, with post-redirect
// fetch flushing and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_CYCLES = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic [1:0]       ex_result_src,
  input  logic             ex_redirect,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             in_redirect,
  output logic [CNT_W-1:0] stall_cycles
);

  state_t            state, state_nxt;
  logic [RCNT_W-1:0] rcnt, rcnt_nxt;
  logic              mem_wait;
  logic              load_use;
  logic [1:0]        fwd_a_c, fwd_b_c;

  assign mem_wait    = dmem_req & ~dmem_ready;
  assign load_use    = (ex_result_src == RESULT_SRC_LOAD) && ex_reg_write && (ex_rd != '0) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign in_redirect = (state == REDIRECT);

  fwd_unit u_fwd_a (
    .rs            (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel_c         (fwd_a_c)
  );

  fwd_unit u_fwd_b (
    .rs            (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel_c         (fwd_b_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RUN;
      rcnt         <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
      if (stall_pc && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

  // Priority: reset, memory wait, redirect, redirect drain, load-use bubble.
  always_comb begin
    state_nxt   = state;
    rcnt_nxt    = rcnt;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    fwd_a_sel   = FWD_RF;
    fwd_b_sel   = FWD_RF;
    if (!rst) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else begin
      fwd_a_sel = fwd_a_c;
      fwd_b_sel = fwd_b_c;
      if (mem_wait) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
      end else if (ex_redirect) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        if (REDIRECT_CYCLES != 0) begin
          state_nxt = REDIRECT;
          rcnt_nxt  = RCNT_W'(REDIRECT_CYCLES);
        end else begin
          state_nxt = RUN;
        end
      end else if (state == REDIRECT) begin
        flush_ifid = 1'b1;
        rcnt_nxt   = rcnt - RCNT_W'(1);
        if (rcnt == RCNT_W'(1)) begin
          state_nxt = RUN;
        end
      end else if (load_use) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then randomized traffic.
module tb_pipe_hazard_ctrl;

  localparam int unsigned RC    = 2;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs1, id_rs2;
    logic       id_uses_rs1, id_uses_rs2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_reg_write;
    logic [1:0] ex_result_src;
    logic       ex_redirect;
    logic [4:0] mem_rd, wb_rd;
    logic       mem_reg_write, wb_reg_write, dmem_req, dmem_ready;
  } stim_t;

  typedef struct {
    logic [3:0] stalls;
    logic [1:0] flushes;
    logic [1:0] fa, fb;
    logic       inr;
    int         scnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_reg_write, ex_redirect;
  logic mem_reg_write, wb_reg_write, dmem_req, dmem_ready;
  logic [1:0] ex_result_src;
  logic stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, in_redirect;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  exp_t sb[$];

  // Reference model state: remaining post-redirect flush cycles and stall count.
  int m_left = 0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REDIRECT_CYCLES(RC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_result_src(ex_result_src), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex), .stall_exmem(stall_exmem),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .in_redirect(in_redirect), .stall_cycles(stall_cycles)
  );

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
    if (s.mem_reg_write && s.mem_rd != 0 && s.mem_rd == rs) return 2'b10;
    if (s.wb_reg_write && s.wb_rd != 0 && s.wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Predict this cycle's outputs from the rules, then advance the model one edge.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    bit hazard;
    hazard = s.ex_result_src == 2'b01 && s.ex_reg_write && s.ex_rd != 0 &&
             ((s.id_uses_rs1 && s.id_rs1 == s.ex_rd) || (s.id_uses_rs2 && s.id_rs2 == s.ex_rd));
    e.stalls = 4'b0000; e.flushes = 2'b00; e.fa = 2'b00; e.fb = 2'b00;
    e.inr = (m_left > 0);
    e.scnt = m_cnt;
    if (!s.rst) begin
      e.flushes = 2'b11;
      m_left = 0;
      m_cnt = 0;
    end else begin
      e.fa = ref_fwd(s.ex_rs1, s);
      e.fb = ref_fwd(s.ex_rs2, s);
      if (s.dmem_req && !s.dmem_ready) e.stalls = 4'b1111;
      else if (s.ex_redirect) begin
        e.flushes = 2'b11;
        m_left = RC;
      end else if (m_left > 0) begin
        e.flushes = 2'b10;
        m_left = m_left - 1;
      end else if (hazard) begin
        e.stalls = 4'b1100;
        e.flushes = 2'b01;
      end
      if (e.stalls[3] && m_cnt < CMAX) m_cnt = m_cnt + 1;
    end
    return e;
  endfunction

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    rst = s.rst;
    id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
    id_uses_rs1 = s.id_uses_rs1; id_uses_rs2 = s.id_uses_rs2;
    ex_rs1 = s.ex_rs1; ex_rs2 = s.ex_rs2; ex_rd = s.ex_rd;
    ex_reg_write = s.ex_reg_write; ex_result_src = s.ex_result_src; ex_redirect = s.ex_redirect;
    mem_rd = s.mem_rd; wb_rd = s.wb_rd; mem_reg_write = s.mem_reg_write; wb_reg_write = s.wb_reg_write;
    dmem_req = s.dmem_req; dmem_ready = s.dmem_ready;
    sb.push_back(model(s));
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic void check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, want);
    end
  endfunction

  // Monitor: outputs are presented every cycle; compare mid-cycle against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("stalls", int'({stall_pc, stall_ifid, stall_idex, stall_exmem}), int'(e.stalls));
        check("flushes", int'({flush_ifid, flush_idex}), int'(e.flushes));
        check("fwd_a_sel", int'(fwd_a_sel), int'(e.fa));
        check("fwd_b_sel", int'(fwd_b_sel), int'(e.fb));
        check("in_redirect", int'(in_redirect), int'(e.inr));
        check("stall_cycles", int'(stall_cycles), e.scnt);
        cyc++;
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b0;
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_reg_write, ex_redirect} = '0;
    {mem_reg_write, wb_reg_write, dmem_req, dmem_ready} = '0;
    ex_result_src = 2'b00;

    // Reset held with a forwarding match and a memory wait present.
    s = idle(); s.rst = 1'b0; s.mem_reg_write = 1'b1; s.mem_rd = 5'd3; s.ex_rs1 = 5'd3;
    s.dmem_req = 1'b1;
    step(s); step(s);
    step(idle());

    // Load-use on rs1, then the bubble, then the x0 case.
    s = idle(); s.ex_result_src = 2'b01; s.ex_reg_write = 1'b1; s.ex_rd = 5'd5;
    s.id_rs1 = 5'd5; s.id_uses_rs1 = 1'b1;
    step(s); step(idle());
    s.ex_rd = 5'd0; s.id_rs1 = 5'd0;
    step(s);

    // Redirect pulse and drain.
    s = idle(); s.ex_redirect = 1'b1;
    step(s);
    for (int i = 0; i < 3; i++) step(idle());

    // Memory wait in the middle of the drain.
    step(s); step(idle());
    s = idle(); s.dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) step(s);
    for (int i = 0; i < 2; i++) step(idle());

    // Forwarding priority and x0.
    s = idle(); s.mem_rd = 5'd7; s.wb_rd = 5'd7; s.mem_reg_write = 1'b1; s.wb_reg_write = 1'b1;
    s.ex_rs1 = 5'd7;
    step(s);
    s.mem_reg_write = 1'b0;
    step(s);
    s.wb_rd = 5'd0; s.ex_rs2 = 5'd0;
    step(s);

    // Redirect together with a load-use match.
    s = idle(); s.ex_redirect = 1'b1; s.ex_result_src = 2'b01; s.ex_reg_write = 1'b1;
    s.ex_rd = 5'd9; s.id_rs2 = 5'd9; s.id_uses_rs2 = 1'b1;
    step(s);
    for (int i = 0; i < 3; i++) step(idle());

    // Drive the counter into saturation.
    s = idle(); s.dmem_req = 1'b1;
    for (int i = 0; i < 20; i++) step(s);
    s = idle(); s.ex_result_src = 2'b01; s.ex_reg_write = 1'b1; s.ex_rd = 5'd2;
    s.id_rs1 = 5'd2; s.id_uses_rs1 = 1'b1;
    step(s); step(idle());

    // Randomized traffic over a small register window to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      s.rst = ($urandom_range(0, 99) != 0);
      s.id_rs1 = 5'($urandom_range(0, 3));
      s.id_rs2 = 5'($urandom_range(0, 3));
      s.id_uses_rs1 = 1'($urandom_range(0, 1));
      s.id_uses_rs2 = 1'($urandom_range(0, 1));
      s.ex_rs1 = 5'($urandom_range(0, 3));
      s.ex_rs2 = 5'($urandom_range(0, 3));
      s.ex_rd = 5'($urandom_range(0, 3));
      s.ex_reg_write = 1'($urandom_range(0, 1));
      s.ex_result_src = 2'($urandom_range(0, 3));
      s.ex_redirect = ($urandom_range(0, 7) == 0);
      s.mem_rd = 5'($urandom_range(0, 3));
      s.wb_rd = 5'($urandom_range(0, 3));
      s.mem_reg_write = 1'($urandom_range(0, 1));
      s.wb_reg_write = 1'($urandom_range(0, 1));
      s.dmem_req = ($urandom_range(0, 2) == 0);
      s.dmem_ready = 1'($urandom_range(0, 1));
      step(s);
    end

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
